// File: rtl/bec_seq_ctrl_if.sv
// Command/strobe bundle between a host sequencer and bec_seq_ctrl.
// The master modport drives commands and core_done; the slave modport is the controller.
interface bec_seq_ctrl_if #(
    parameter int NSEG = 14
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [3:0]      cmd_seg;
    logic            ld_en;
    logic [3:0]      ld_sel;
    logic            core_start;
    logic            core_done;
    logic            rd_en;
    logic [3:0]      rd_sel;
    logic [NSEG-1:0] loaded_mask;
    logic [2:0]      state_o;
    logic            busy;
    logic            err;
    logic [1:0]      err_code;

    modport master (
        output cmd_valid, cmd_op, cmd_seg, core_done,
        input  cmd_ready, ld_en, ld_sel, core_start, rd_en, rd_sel,
               loaded_mask, state_o, busy, err, err_code
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_seg, core_done,
        output cmd_ready, ld_en, ld_sel, core_start, rd_en, rd_sel,
               loaded_mask, state_o, busy, err, err_code
    );
endinterface

// File: rtl/bec_seq_ctrl.sv
// Sequencer for an operand-load / run / result-read processing core.
// Enforces in-order segment loading, times out the core, and latches the first error cause.
module bec_seq_ctrl #(
    parameter int NSEG    = 14,
    parameter int NRD     = 4,
    parameter int TIMEOUT = 2000
) (
    input logic            wb_clk_i,
    input logic            wb_rst_i,
    bec_seq_ctrl_if.slave  bus
);
    localparam int NW = $clog2(NSEG + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ARMED = 3'd2,
        S_RUN   = 3'd3,
        S_READ  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_START = 2'b01,
        OP_READ  = 2'b10,
        OP_ABORT = 2'b11
    } op_t;

    localparam logic [1:0] E_NONE    = 2'b00;
    localparam logic [1:0] E_ORDER   = 2'b01;
    localparam logic [1:0] E_ILLEGAL = 2'b10;
    localparam logic [1:0] E_TIMEOUT = 2'b11;

    state_t          state_q, state_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [NW-1:0]   nxt_q, nxt_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [NSEG-1:0] mask_q, mask_d;
    logic            ld_en_q, ld_en_d;
    logic [3:0]      ld_sel_q, ld_sel_d;
    logic            core_start_q, core_start_d;
    logic            rd_en_q, rd_en_d;
    logic [3:0]      rd_sel_q, rd_sel_d;

    logic cmd_ready;
    logic acc, abort;
    logic load_ok, reload_ok, read_ok, last_seg, timeout_hit;
    op_t  op;

    assign cmd_ready   = ~wb_rst_i;
    assign op          = op_t'(bus.cmd_op);
    assign acc         = bus.cmd_valid & cmd_ready;
    assign abort       = acc && (op == OP_ABORT);
    assign load_ok     = ((state_q == S_IDLE) || (state_q == S_LOAD))
                         && (int'(bus.cmd_seg) < NSEG)
                         && (int'(bus.cmd_seg) == int'(nxt_q));
    // A finished job may be reloaded from READ only by restarting at segment 0.
    assign reload_ok   = (state_q == S_READ) && (bus.cmd_seg == 4'd0);
    assign read_ok     = (state_q == S_READ) && (int'(bus.cmd_seg) < NRD);
    assign last_seg    = (int'(bus.cmd_seg) == NSEG - 1);
    assign timeout_hit = (int'(timer_q) == TIMEOUT - 1);

    // NOTE: the reset branch is asynchronous so outputs clear between edges, not at the next clock.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= S_IDLE;
            err_code_q <= E_NONE;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
        end
    end

    // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        if (abort) begin
            state_d    = S_IDLE;
            err_code_d = E_NONE;
        end else if (state_q == S_ERR) begin
            state_d = S_ERR;
        end else if (acc) begin
            case (op)
                OP_LOAD: begin
                    if (load_ok || reload_ok) begin
                        state_d = last_seg ? S_ARMED : S_LOAD;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = (state_q == S_RUN) ? E_ILLEGAL : E_ORDER;
                    end
                end
                OP_START: begin
                    if (state_q == S_ARMED) begin
                        state_d = S_RUN;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = E_ILLEGAL;
                    end
                end
                OP_READ: begin
                    if (!read_ok) begin
                        state_d    = S_ERR;
                        err_code_d = E_ILLEGAL;
                    end
                end
                OP_ABORT: ;
            endcase
        end else if (state_q == S_RUN) begin
            if (bus.core_done) begin
                state_d = S_READ;
            end else if (timeout_hit) begin
                state_d    = S_ERR;
                err_code_d = E_TIMEOUT;
            end
        end
    end

    always_comb begin
        ld_en_d      = 1'b0;
        core_start_d = 1'b0;
        rd_en_d      = 1'b0;
        ld_sel_d     = ld_sel_q;
        rd_sel_d     = rd_sel_q;
        mask_d       = mask_q;
        nxt_d        = nxt_q;
        timer_d      = (state_q == S_RUN) ? timer_q + TW'(1) : timer_q;
        if (abort) begin
            mask_d  = '0;
            nxt_d   = '0;
            timer_d = '0;
        end else if (acc && (state_q != S_ERR)) begin
            case (op)
                OP_LOAD: begin
                    if (load_ok) begin
                        ld_en_d  = 1'b1;
                        ld_sel_d = bus.cmd_seg;
                        mask_d   = mask_q | (NSEG'(1) << bus.cmd_seg);
                        nxt_d    = nxt_q + NW'(1);
                    end else if (reload_ok) begin
                        ld_en_d  = 1'b1;
                        ld_sel_d = 4'd0;
                        mask_d   = NSEG'(1);
                        nxt_d    = NW'(1);
                    end
                end
                OP_START: begin
                    if (state_q == S_ARMED) begin
                        core_start_d = 1'b1;
                        timer_d      = '0;
                    end
                end
                OP_READ: begin
                    if (read_ok) begin
                        rd_en_d  = 1'b1;
                        rd_sel_d = bus.cmd_seg;
                    end
                end
                OP_ABORT: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            nxt_q        <= '0;
            timer_q      <= '0;
            mask_q       <= '0;
            ld_en_q      <= 1'b0;
            ld_sel_q     <= 4'd0;
            core_start_q <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_sel_q     <= 4'd0;
        end else begin
            nxt_q        <= nxt_d;
            timer_q      <= timer_d;
            mask_q       <= mask_d;
            ld_en_q      <= ld_en_d;
            ld_sel_q     <= ld_sel_d;
            core_start_q <= core_start_d;
            rd_en_q      <= rd_en_d;
            rd_sel_q     <= rd_sel_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.ld_en       = ld_en_q;
    assign bus.ld_sel      = ld_sel_q;
    assign bus.core_start  = core_start_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.rd_sel      = rd_sel_q;
    assign bus.loaded_mask = mask_q;
    assign bus.state_o     = state_q;
    assign bus.busy        = (state_q == S_RUN);
    assign bus.err         = (state_q == S_ERR);
    assign bus.err_code    = err_code_q;
endmodule

// File: tb/tb_bec_seq_ctrl.sv
// Self-checking bench for bec_seq_ctrl: directed scenarios then randomized commands,
// compared each cycle against a transaction-level model of the sequencer rules.
module tb_bec_seq_ctrl;
    localparam int NSEG    = 14;
    localparam int NRD     = 4;
    localparam int TIMEOUT = 200;

    localparam int M_IDLE = 0, M_LOAD = 1, M_ARMED = 2, M_RUN = 3, M_READ = 4, M_ERR = 5;
    localparam logic [1:0] C_LOAD = 2'b00, C_START = 2'b01, C_READ = 2'b10, C_ABORT = 2'b11;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;

    bec_seq_ctrl_if #(.NSEG(NSEG)) bus ();

    bec_seq_ctrl #(.NSEG(NSEG), .NRD(NRD), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Model: state, the ordered list of segments loaded so far, error cause, run start edge.
    int m_st = M_IDLE;
    int m_loaded[$];
    int m_ec = 0;
    int m_start = 0;
    bit m_ld, m_cs, m_rd;
    int m_ld_sel, m_rd_sel;

    int ld_pulses, cs_pulses, rd_pulses, busy_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_mask();
        int m = 0;
        foreach (m_loaded[i]) m |= (1 << m_loaded[i]);
        return m;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE;
        m_loaded.delete();
        m_ec = 0;
    endtask

    task automatic model_err(input int code);
        m_ec = code;
        m_st = M_ERR;
    endtask

    task automatic model_step(input bit v, input int op, input int seg, input bit done);
        m_ld = 0; m_cs = 0; m_rd = 0;
        if (v && op == 3) begin
            model_reset();
        end else if (m_st == M_ERR) begin
            m_st = M_ERR;
        end else if (v) begin
            case (op)
                0: begin
                    if (((m_st == M_IDLE || m_st == M_LOAD) && seg == m_loaded.size() && seg < NSEG)
                        || (m_st == M_READ && seg == 0)) begin
                        if (m_st == M_READ) m_loaded.delete();
                        m_loaded.push_back(seg);
                        m_ld = 1; m_ld_sel = seg;
                        m_st = (seg == NSEG - 1) ? M_ARMED : M_LOAD;
                    end else begin
                        model_err((m_st == M_RUN) ? 2 : 1);
                    end
                end
                1: begin
                    if (m_st == M_ARMED) begin
                        m_cs = 1; m_st = M_RUN; m_start = cyc;
                    end else model_err(2);
                end
                default: begin
                    if (m_st == M_READ && seg < NRD) begin
                        m_rd = 1; m_rd_sel = seg;
                    end else model_err(2);
                end
            endcase
        end else if (m_st == M_RUN) begin
            if (done) m_st = M_READ;
            else if (cyc - m_start == TIMEOUT) model_err(3);
        end
    endtask

    task automatic cycle(input bit v, input logic [1:0] op, input logic [3:0] seg, input bit done);
        bus.cmd_valid = v;
        bus.cmd_op    = op;
        bus.cmd_seg   = seg;
        bus.core_done = done;
        cyc++;
        model_step(v, int'(op), int'(seg), done);
        @(posedge wb_clk_i);
        #1;
        chk("state", bus.state_o, m_st);
        chk("ld_en", bus.ld_en, m_ld);
        chk("core_start", bus.core_start, m_cs);
        chk("rd_en", bus.rd_en, m_rd);
        if (m_ld) chk("ld_sel", bus.ld_sel, m_ld_sel);
        if (m_rd) chk("rd_sel", bus.rd_sel, m_rd_sel);
        chk("loaded_mask", bus.loaded_mask, model_mask());
        chk("busy", bus.busy, m_st == M_RUN);
        chk("err", bus.err, m_st == M_ERR);
        chk("err_code", bus.err_code, m_ec);
        chk("cmd_ready", bus.cmd_ready, 1);
        ld_pulses   += bus.ld_en;
        cs_pulses   += bus.core_start;
        rd_pulses   += bus.rd_en;
        busy_cycles += bus.busy;
    endtask

    task automatic idle(input bit done);
        cycle(1'b0, C_LOAD, 4'd0, done);
    endtask

    task automatic load_all();
        for (int s = 0; s < NSEG; s++) cycle(1'b1, C_LOAD, 4'(s), 1'b0);
    endtask

    task automatic clear_counts();
        ld_pulses = 0; cs_pulses = 0; rd_pulses = 0; busy_cycles = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = C_LOAD;
        bus.cmd_seg   = 4'd0;
        bus.core_done = 1'b0;

        // Reset values
        @(negedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_state", bus.state_o, M_IDLE);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_strobes", {bus.ld_en, bus.core_start, bus.rd_en}, 0);
        chk("rst_sels", {bus.ld_sel, bus.rd_sel}, 0);
        chk("rst_mask", bus.loaded_mask, 0);
        chk("rst_flags", {bus.busy, bus.err, bus.err_code}, 0);
        wb_rst_i = 1'b0;
        model_reset();

        // In-order load of every segment
        clear_counts();
        load_all();
        chk("load_pulses", ld_pulses, NSEG);
        chk("load_mask_full", bus.loaded_mask, 14'h3FFF);
        chk("load_armed", bus.state_o, M_ARMED);

        // Start, core_done sampled on the 50th edge after start, then two reads
        clear_counts();
        cycle(1'b1, C_START, 4'd0, 1'b0);
        for (int k = 1; k <= 50; k++) idle(k == 50);
        chk("run_start_pulses", cs_pulses, 1);
        chk("run_busy_cycles", busy_cycles, 50);
        chk("run_to_read", bus.state_o, M_READ);
        cycle(1'b1, C_READ, 4'd3, 1'b0);
        chk("read_sel_3", bus.rd_sel, 3);
        cycle(1'b1, C_READ, 4'd0, 1'b0);
        chk("read_sel_0", bus.rd_sel, 0);
        chk("read_pulses", rd_pulses, 2);

        // Out-of-order load, sticky error, abort recovery
        cycle(1'b1, C_ABORT, 4'd0, 1'b0);
        clear_counts();
        cycle(1'b1, C_LOAD, 4'd0, 1'b0);
        cycle(1'b1, C_LOAD, 4'd1, 1'b0);
        cycle(1'b1, C_LOAD, 4'd3, 1'b0);
        chk("ooo_err", bus.err, 1);
        chk("ooo_code", bus.err_code, 2'b01);
        chk("ooo_pulses", ld_pulses, 2);
        cycle(1'b1, C_START, 4'd0, 1'b0);
        chk("err_sticky", bus.state_o, M_ERR);
        cycle(1'b1, C_ABORT, 4'd0, 1'b0);
        chk("abort_idle", bus.state_o, M_IDLE);
        chk("abort_mask", bus.loaded_mask, 0);

        // Timeout: err must appear exactly TIMEOUT cycles after the core_start pulse
        load_all();
        cycle(1'b1, C_START, 4'd0, 1'b0);
        n = 0;
        while (!bus.err && n < TIMEOUT + 10) begin
            idle(1'b0);
            n++;
        end
        chk("timeout_latency", n, TIMEOUT);
        chk("timeout_code", bus.err_code, 2'b11);

        // core_done on the timeout cycle wins
        cycle(1'b1, C_ABORT, 4'd0, 1'b0);
        load_all();
        cycle(1'b1, C_START, 4'd0, 1'b0);
        for (int k = 1; k <= TIMEOUT; k++) idle(k == TIMEOUT);
        chk("done_beats_timeout", bus.state_o, M_READ);

        // Asynchronous reset between clock edges mid-RUN
        cycle(1'b1, C_ABORT, 4'd0, 1'b0);
        load_all();
        cycle(1'b1, C_START, 4'd0, 1'b0);
        for (int k = 0; k < 10; k++) idle(1'b0);
        #3 wb_rst_i = 1'b1;
        #1;
        chk("arst_state", bus.state_o, M_IDLE);
        chk("arst_busy", bus.busy, 0);
        chk("arst_mask", bus.loaded_mask, 0);
        chk("arst_ready", bus.cmd_ready, 0);
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();
        clear_counts();
        load_all();
        cycle(1'b1, C_START, 4'd0, 1'b0);
        for (int k = 1; k <= 5; k++) idle(k == 5);
        cycle(1'b1, C_READ, 4'd2, 1'b0);
        cycle(1'b1, C_READ, 4'd1, 1'b0);
        chk("post_rst_pulses", {8'(ld_pulses), 8'(cs_pulses), 8'(rd_pulses)}, {8'(NSEG), 8'd1, 8'd2});
        cycle(1'b1, C_LOAD, 4'd0, 1'b0);
        chk("reload_seg0_mask", bus.loaded_mask, 1);

        // Randomized commands against the model
        for (int i = 0; i < 3000; i++) begin
            bit v, d;
            logic [1:0] op;
            logic [3:0] seg;
            int r;
            v = ($urandom_range(0, 99) < ((m_st == M_RUN) ? 4 : 70));
            r = $urandom_range(0, 99);
            if (r < 50)      op = C_LOAD;
            else if (r < 65) op = C_START;
            else if (r < 94) op = C_READ;
            else             op = C_ABORT;
            if (op == C_LOAD && $urandom_range(0, 9) < 8) seg = 4'(m_loaded.size());
            else if (op == C_READ)                        seg = 4'($urandom_range(0, 5));
            else                                          seg = 4'($urandom_range(0, 15));
            d = ($urandom_range(0, 99) < 8);
            cycle(v, op, seg, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
